// File: rtl/if_icache_pkg.sv
// if_icache_pkg: shared defines for the instruction cache slice
package if_icache_pkg;
  localparam int AddrLen = 32;
  localparam int RegLen = 32;
  localparam logic [RegLen-1:0] ZERO_WORD = '0;
  localparam logic True = 1'b1;
  localparam logic False = 1'b0;
  localparam logic Enable = 1'b1;
  localparam logic Disable = 1'b0;
  localparam int ICACHE_INDEX_BITS = 7;
  typedef enum logic {IDLE, MISS} state_t;
endpackage

// File: rtl/if_icache_array.sv
// icache_array: valid/tag/data storage with combinational read and one write port
module icache_array
  import if_icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int ADDR_LEN = AddrLen
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_we,
  input  logic [ADDR_LEN-3:0] i_wpc,
  input  logic [RegLen-1:0]   i_wdata,
  input  logic [ADDR_LEN-3:0] i_rpc,
  output logic                o_hit,
  output logic [RegLen-1:0]   o_data
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_LEN - 2 - INDEX_BITS;
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [LINES];
  logic [RegLen-1:0] r_data [LINES];
  logic [INDEX_BITS-1:0] w_ridx, w_widx;
  assign w_ridx = i_rpc[INDEX_BITS-1:0];
  assign w_widx = i_wpc[INDEX_BITS-1:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_valid <= '0;
    else if (i_we) r_valid[w_widx] <= True;
  end
  // tag/data carry no reset; a cleared valid bit masks them
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[w_widx] <= i_wpc[ADDR_LEN-3:INDEX_BITS];
      r_data[w_widx] <= i_wdata;
    end
  end
  assign o_hit = r_valid[w_ridx] && (r_tag[w_ridx] == i_rpc[ADDR_LEN-3:INDEX_BITS]);
  assign o_data = r_data[w_ridx];
endmodule

// File: rtl/if_icache.sv
// if_icache: direct-mapped instruction cache between IF and the memory controller
module if_icache
  import if_icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int ADDR_LEN = AddrLen
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                if_req_i,
  input  logic [ADDR_LEN-1:0] if_pc_i,
  input  logic                if_jump_i,
  output logic                if_inst_valid_o,
  output logic [RegLen-1:0]   if_inst_o,
  output logic [ADDR_LEN-1:0] if_inst_pc_o,
  output logic                mc_req_o,
  output logic [ADDR_LEN-1:0] mc_pc_o,
  output logic                mc_jump_o,
  input  logic                mc_inst_ready_i,
  input  logic [RegLen-1:0]   mc_inst_i
);
  state_t r_state, w_next;
  logic [ADDR_LEN-1:0] r_miss_pc, r_inst_pc;
  logic [RegLen-1:0] r_inst, w_data;
  logic r_valid, r_mc_req, r_mc_jump;
  logic w_hit, w_req, w_fill, w_ret_hit, w_ret_fill, w_load_pc, w_jump;
  icache_array #(.INDEX_BITS(INDEX_BITS), .ADDR_LEN(ADDR_LEN)) u_array (
    .clk(clk), .rst(rst), .i_we(w_fill), .i_wpc(r_miss_pc[ADDR_LEN-1:2]), .i_wdata(mc_inst_i),
    .i_rpc(if_pc_i[ADDR_LEN-1:2]), .o_hit(w_hit), .o_data(w_data)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else if (rdy) r_state <= w_next;
  end
  always_comb begin
    w_req = if_req_i | if_jump_i;
    w_next = (r_state == IDLE) ? ((w_req && !w_hit) ? MISS : IDLE)
           : (if_jump_i ? (w_hit ? IDLE : MISS) : (mc_inst_ready_i ? IDLE : MISS));
  end
  // a fill coinciding with a jump still writes the old line but is not returned
  always_comb begin
    w_fill = rdy && (r_state == MISS) && mc_inst_ready_i;
    w_jump = (r_state == MISS) && if_jump_i;
    w_ret_hit = ((r_state == IDLE) ? w_req : if_jump_i) && w_hit;
    w_ret_fill = (r_state == MISS) && mc_inst_ready_i && !if_jump_i;
    w_load_pc = (w_next == MISS) && ((r_state == IDLE) || if_jump_i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= False;
      r_inst <= ZERO_WORD;
      r_inst_pc <= '0;
      r_miss_pc <= '0;
      r_mc_req <= Disable;
      r_mc_jump <= Disable;
    end else if (rdy) begin
      r_valid <= w_ret_hit | w_ret_fill;
      if (w_ret_hit | w_ret_fill) begin
        r_inst <= w_ret_hit ? w_data : mc_inst_i;
        r_inst_pc <= w_ret_hit ? if_pc_i : r_miss_pc;
      end
      if (w_load_pc) r_miss_pc <= if_pc_i;
      r_mc_req <= (w_next == MISS) ? Enable : Disable;
      r_mc_jump <= w_jump;
    end
  end
  assign if_inst_valid_o = r_valid;
  assign if_inst_o = r_inst;
  assign if_inst_pc_o = r_inst_pc;
  assign mc_req_o = r_mc_req;
  assign mc_pc_o = r_miss_pc;
  assign mc_jump_o = r_mc_jump;
endmodule

// File: tb/tb_if_icache.sv
// tb_if_icache: directed and randomized checks against a line-level cache model
module tb_if_icache;
  logic clk = 0, rst = 1, rdy = 1, if_req_i = 0, if_jump_i = 0, mc_inst_ready_i = 0;
  logic [31:0] if_pc_i = 0, mc_inst_i = 0;
  logic if_inst_valid_o, mc_req_o, mc_jump_o;
  logic [31:0] if_inst_o, if_inst_pc_o, mc_pc_o;
  int checks = 0, errors = 0;
  bit m_valid [128];
  logic [31:0] m_pc [128];
  logic [31:0] m_data [128];

  always #5 clk = ~clk;

  if_icache dut (
    .clk(clk), .rst(rst), .rdy(rdy), .if_req_i(if_req_i), .if_pc_i(if_pc_i), .if_jump_i(if_jump_i),
    .if_inst_valid_o(if_inst_valid_o), .if_inst_o(if_inst_o), .if_inst_pc_o(if_inst_pc_o),
    .mc_req_o(mc_req_o), .mc_pc_o(mc_pc_o), .mc_jump_o(mc_jump_o),
    .mc_inst_ready_i(mc_inst_ready_i), .mc_inst_i(mc_inst_i)
  );

  function automatic int line_of(input logic [31:0] pc);
    return int'((pc >> 2) % 128);
  endfunction
  function automatic bit mhit(input logic [31:0] pc);
    return m_valid[line_of(pc)] && m_pc[line_of(pc)] == pc;
  endfunction
  task automatic mfill(input logic [31:0] pc, input logic [31:0] w);
    m_valid[line_of(pc)] = 1; m_pc[line_of(pc)] = pc; m_data[line_of(pc)] = w;
  endtask
  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] w, input int lat);
    bit h;
    logic [31:0] e;
    h = mhit(pc);
    e = h ? m_data[line_of(pc)] : w;
    if_req_i = 1; if_pc_i = pc; step; if_req_i = 0;
    checks++; if (mc_req_o !== (h ? 1'b0 : 1'b1)) begin errors++; $display("FAIL fetch_req pc=%h got %b exp %b", pc, mc_req_o, !h); end
    if (!h) begin
      checks++; if (mc_pc_o !== pc) begin errors++; $display("FAIL fetch_mc_pc got %h exp %h", mc_pc_o, pc); end
      repeat (lat) step;
      checks++; if (mc_req_o !== 1'b1 || if_inst_valid_o !== 1'b0) begin errors++; $display("FAIL fetch_wait req=%b valid=%b exp 1/0", mc_req_o, if_inst_valid_o); end
      mc_inst_ready_i = 1; mc_inst_i = w; step; mc_inst_ready_i = 0;
      mfill(pc, w);
      checks++; if (mc_req_o !== 1'b0) begin errors++; $display("FAIL fetch_req_drop got %b exp 0", mc_req_o); end
    end
    checks++; if ({if_inst_valid_o, if_inst_o, if_inst_pc_o} !== {1'b1, e, pc}) begin errors++; $display("FAIL fetch_ret got %b %h %h exp 1 %h %h", if_inst_valid_o, if_inst_o, if_inst_pc_o, e, pc); end
    checks++; if (mc_jump_o !== 1'b0) begin errors++; $display("FAIL fetch_jump got %b exp 0", mc_jump_o); end
  endtask

  task automatic jump_case(input logic [31:0] pc, input logic [31:0] pc2, input bit co, input logic [31:0] w1, input logic [31:0] w2);
    bit h2;
    logic [31:0] e2;
    if_req_i = 1; if_pc_i = pc; step; if_req_i = 0; step;
    h2 = mhit(pc2);
    e2 = m_data[line_of(pc2)];
    if_jump_i = 1; if_pc_i = pc2; mc_inst_ready_i = co; mc_inst_i = w1; step;
    if_jump_i = 0; mc_inst_ready_i = 0;
    if (co) mfill(pc, w1);
    checks++; if (mc_jump_o !== 1'b1) begin errors++; $display("FAIL jump_pulse got %b exp 1", mc_jump_o); end
    checks++; if (mc_req_o !== (h2 ? 1'b0 : 1'b1) || if_inst_valid_o !== h2) begin errors++; $display("FAIL jump_req req=%b valid=%b exp hit=%b", mc_req_o, if_inst_valid_o, h2); end
    if (h2) begin
      checks++; if ({if_inst_o, if_inst_pc_o} !== {e2, pc2}) begin errors++; $display("FAIL jump_hit_ret got %h %h exp %h %h", if_inst_o, if_inst_pc_o, e2, pc2); end
    end else begin
      checks++; if (mc_pc_o !== pc2) begin errors++; $display("FAIL jump_mc_pc got %h exp %h", mc_pc_o, pc2); end
    end
    step;
    checks++; if (mc_jump_o !== 1'b0 || if_inst_valid_o !== 1'b0) begin errors++; $display("FAIL jump_after jump=%b valid=%b exp 0/0", mc_jump_o, if_inst_valid_o); end
    if (!h2) begin
      mc_inst_ready_i = 1; mc_inst_i = w2; step; mc_inst_ready_i = 0;
      mfill(pc2, w2);
      checks++; if ({if_inst_valid_o, if_inst_o, if_inst_pc_o, mc_req_o} !== {1'b1, w2, pc2, 1'b0}) begin errors++; $display("FAIL jump_fill_ret got %b %h %h req=%b exp 1 %h %h 0", if_inst_valid_o, if_inst_o, if_inst_pc_o, mc_req_o, w2, pc2); end
    end
  endtask

  task automatic test_reset;
    #2;
    checks++; if ({if_inst_valid_o, if_inst_o, if_inst_pc_o, mc_req_o, mc_pc_o, mc_jump_o} !== '0) begin errors++; $display("FAIL reset_outputs got %b %h %h %b %h %b exp all 0", if_inst_valid_o, if_inst_o, if_inst_pc_o, mc_req_o, mc_pc_o, mc_jump_o); end
    step; step; rst = 0; step;
  endtask

  task automatic test_cold_miss;
    fetch(32'h0, 32'h00500093, 2);
  endtask

  task automatic test_back_to_back;
    fetch(32'h0, 32'h0, 0);
    fetch(32'h4, 32'h00a00113, 1);
    if_req_i = 1; if_pc_i = 32'h0; step;
    checks++; if ({if_inst_valid_o, if_inst_o, if_inst_pc_o, mc_req_o} !== {1'b1, 32'h00500093, 32'h0, 1'b0}) begin errors++; $display("FAIL b2b_first got %b %h %h %b", if_inst_valid_o, if_inst_o, if_inst_pc_o, mc_req_o); end
    if_pc_i = 32'h4; step; if_req_i = 0;
    checks++; if ({if_inst_valid_o, if_inst_o, if_inst_pc_o, mc_req_o} !== {1'b1, 32'h00a00113, 32'h4, 1'b0}) begin errors++; $display("FAIL b2b_second got %b %h %h %b", if_inst_valid_o, if_inst_o, if_inst_pc_o, mc_req_o); end
    step;
    checks++; if (if_inst_valid_o !== 1'b0 || if_inst_o !== 32'h00a00113) begin errors++; $display("FAIL b2b_idle valid=%b inst=%h exp 0 held", if_inst_valid_o, if_inst_o); end
    if_jump_i = 1; if_pc_i = 32'h0; step; if_jump_i = 0;
    checks++; if ({if_inst_valid_o, if_inst_pc_o, mc_jump_o, mc_req_o} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin errors++; $display("FAIL idle_jump got %b %h %b %b", if_inst_valid_o, if_inst_pc_o, mc_jump_o, mc_req_o); end
  endtask

  task automatic test_conflict;
    fetch(32'h200, 32'h12345678, 0);
    fetch(32'h0, 32'h00500093, 3);
  endtask

  task automatic test_jump_mid_miss;
    jump_case(32'h10, 32'h80, 0, 32'h0, 32'hDEADBEEF);
    jump_case(32'h14, 32'h80, 0, 32'h0, 32'h0);
  endtask

  task automatic test_jump_ready;
    jump_case(32'h10, 32'h40, 1, 32'hA5A50010, 32'h0BADF00D);
    if_req_i = 1; if_pc_i = 32'h10; step; if_req_i = 0;
    checks++; if ({if_inst_valid_o, if_inst_o, mc_req_o} !== {1'b1, 32'hA5A50010, 1'b0}) begin errors++; $display("FAIL coincident_fill_hit got %b %h %b", if_inst_valid_o, if_inst_o, mc_req_o); end
  endtask

  task automatic test_rdy;
    if_req_i = 1; if_pc_i = 32'h300; step; if_req_i = 0;
    rdy = 0; mc_inst_ready_i = 1; mc_inst_i = 32'h11111111; step; step; mc_inst_ready_i = 0;
    checks++; if (if_inst_valid_o !== 1'b0 || mc_req_o !== 1'b1) begin errors++; $display("FAIL rdy_hold valid=%b req=%b exp 0/1", if_inst_valid_o, mc_req_o); end
    rdy = 1; step;
    checks++; if ({if_inst_valid_o, mc_req_o, mc_pc_o} !== {1'b0, 1'b1, 32'h300}) begin errors++; $display("FAIL rdy_nofill got %b %b %h", if_inst_valid_o, mc_req_o, mc_pc_o); end
    mc_inst_ready_i = 1; mc_inst_i = 32'h22222222; step; mc_inst_ready_i = 0;
    mfill(32'h300, 32'h22222222);
    checks++; if ({if_inst_valid_o, if_inst_o, if_inst_pc_o} !== {1'b1, 32'h22222222, 32'h300}) begin errors++; $display("FAIL rdy_fill got %b %h %h", if_inst_valid_o, if_inst_o, if_inst_pc_o); end
    fetch(32'h300, 32'h0, 0);
  endtask

  task automatic test_async_reset;
    if_req_i = 1; if_pc_i = 32'h500; step; if_req_i = 0;
    mc_inst_ready_i = 0;
    rst = 1; #1;
    checks++; if (mc_req_o !== 1'b0 || if_inst_valid_o !== 1'b0) begin errors++; $display("FAIL async_reset req=%b valid=%b exp 0/0", mc_req_o, if_inst_valid_o); end
    step; step; rst = 0;
    for (int i = 0; i < 128; i++) m_valid[i] = 0;
    step;
    fetch(32'h0, 32'h00700193, 1);
    fetch(32'h80, 32'hCAFEF00D, 0);
  endtask

  task automatic test_random;
    logic [31:0] pc, pc2;
    for (int n = 0; n < 80; n++) begin
      pc = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2);
      pc2 = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2);
      if (!mhit(pc) && $urandom_range(0, 2) == 0)
        jump_case(pc, pc2, $urandom_range(0, 1) == 1, $urandom, $urandom);
      else
        fetch(pc, $urandom, $urandom_range(0, 3));
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) m_valid[i] = 0;
    test_reset;
    test_cold_miss;
    test_back_to_back;
    test_conflict;
    test_jump_mid_miss;
    test_jump_ready;
    test_rdy;
    test_async_reset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
